uart_mmio: RTL and testbench

UART_MMIO -- requirements
Module: uart_mmio

---
 rtl/uart_mmio.sv | 154 +++++++++++++++
 tb/tb_uart_mmio.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// MMIO UART: TXDATA/STATUS/RXDATA registers, TX FIFO drained by a paced emitter; `UART_MMIO_RX_EN enables RXDATA.
// Latency: response 1 cycle after acceptance; first character out 2 cycles after its write.
// Backpressure: req_ready drops only for a TXDATA write while the FIFO is full.
module uart_mmio #(
    parameter int FIFO_DEPTH = 8,
    parameter int TX_GAP     = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [3:0]  req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        uart_out_valid,
    output logic [7:0]  uart_out_ch,
    output logic        uart_in_valid,
    input  logic [7:0]  uart_in_ch
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int GW = $clog2(TX_GAP + 2);
    localparam logic [3:0] A_TX = 4'h0;
    localparam logic [3:0] A_ST = 4'h4;
    localparam logic [3:0] A_RX = 4'h8;

    typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    tx_state_t     state_q;
    logic [GW-1:0] gap_q;
    logic          rsp_valid_q, out_valid_q;
    logic [63:0]   rsp_rdata_q, rsp_rdata_d;
    logic [7:0]    out_ch_q;
    logic          full, empty, accept, push, pop, rx_en;

    assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign req_ready = reset || !(req_wen && (req_addr == A_TX) && full);
    assign accept    = req_valid && req_ready && !reset;
    assign push      = accept && req_wen && (req_addr == A_TX);
    assign pop       = (state_q == SEND);

`ifdef UART_MMIO_RX_EN
    assign rx_en         = 1'b1;
    assign uart_in_valid = accept && !req_wen && (req_addr == A_RX);
`else
    assign rx_en         = 1'b0;
    assign uart_in_valid = 1'b0;
`endif

    // Status reflects occupancy before this cycle's push/pop.
    always_comb begin
        rsp_rdata_d = '0;
        if (!req_wen) begin
            case (req_addr)
                A_ST: begin
                    rsp_rdata_d[0]    = full;
                    rsp_rdata_d[1]    = empty;
                    rsp_rdata_d[2]    = rx_en;
                    rsp_rdata_d[15:8] = 8'(count_q);
                end
                A_RX:    rsp_rdata_d[7:0] = rx_en ? uart_in_ch : 8'h00;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= accept;
            rsp_rdata_q <= accept ? rsp_rdata_d : '0;
        end
    end

    // A back-to-back SEND only follows when a second entry was already stored,
    // so a fresh write never reaches the output sooner than two cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= 8'h00;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q     <= SEND;
                        out_valid_q <= 1'b1;
                        out_ch_q    <= mem_q[rd_ptr_q];
                    end
                end
                SEND: begin
                    if (TX_GAP > 0) begin
                        state_q <= GAP;
                        gap_q   <= GW'(TX_GAP - 1);
                    end else if (count_q > (AW+1)'(1)) begin
                        state_q     <= SEND;
                        out_valid_q <= 1'b1;
                        out_ch_q    <= mem_q[rd_ptr_q + AW'(1)];
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - GW'(1);
                    end else if (!empty) begin
                        state_q     <= SEND;
                        out_valid_q <= 1'b1;
                        out_ch_q    <= mem_q[rd_ptr_q];
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign uart_out_valid = out_valid_q;
    assign uart_out_ch    = out_ch_q;
endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: two instances (TX_GAP 0 and 4) against a queue-based emission model plus literal checks.
module tb_uart_mmio;
    localparam int DEPTH = 8;
`ifdef UART_MMIO_RX_EN
    localparam bit RXEN = 1'b1;
`else
    localparam bit RXEN = 1'b0;
`endif
    localparam logic [63:0] RXBIT = RXEN ? 64'h4 : 64'h0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic vld0 = 1'b0, vld1 = 1'b0, req_wen = 1'b0;
    logic [3:0] req_addr = 4'h0;
    logic [7:0] req_wdata = 8'h00, uart_in_ch = 8'h00;
    logic [1:0] rdy, rv, ov, iv;
    logic [1:0][63:0] rdat;
    logic [1:0][7:0] och;

    uart_mmio #(.FIFO_DEPTH(DEPTH), .TX_GAP(0)) u_gap0 (
        .clock(clock), .reset(reset), .req_valid(vld0), .req_ready(rdy[0]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[0]), .rsp_rdata(rdat[0]), .uart_out_valid(ov[0]),
        .uart_out_ch(och[0]), .uart_in_valid(iv[0]), .uart_in_ch(uart_in_ch));

    uart_mmio #(.FIFO_DEPTH(DEPTH), .TX_GAP(4)) u_gap4 (
        .clock(clock), .reset(reset), .req_valid(vld1), .req_ready(rdy[1]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_rdata(rdat[1]), .uart_out_valid(ov[1]),
        .uart_out_ch(och[1]), .uart_in_valid(iv[1]), .uart_in_ch(uart_in_ch));

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: each character becomes eligible 2 cycles after acceptance; emissions
    // are spaced at least 1+TX_GAP cycles apart; occupancy is the unemitted count.
    int mch [2][64];
    int mav [2][64];
    int mhead [2], mtail [2], mslot [2];
    bit mrv [2];
    logic [63:0] mrd [2];
    int cyc = 0;
    bit rst_prev = 1'b1;

    int ecnt [2], acc_cyc [2], rsp_cyc [2], inv_cnt [2];
    int ecyc [2][32];
    logic [7:0] ech [2][32];
    bit stall_seen [2];

    function automatic int gapof(input int d);
        return (d == 0) ? 0 : 4;
    endfunction

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            logic v;
            int size;
            bit exp_rdy, acc, emit, exp_iv;
            logic [63:0] rd;
            v = (d == 0) ? vld0 : vld1;
            if (ov[d]) begin
                if (ecnt[d] < 32) begin
                    ecyc[d][ecnt[d]] = cyc;
                    ech[d][ecnt[d]] = och[d];
                end
                ecnt[d]++;
            end
            if (v && rdy[d] && !reset) acc_cyc[d] = cyc;
            if (rv[d]) rsp_cyc[d] = cyc;
            if (iv[d]) inv_cnt[d]++;
            if (v && !rdy[d]) stall_seen[d] = 1'b1;
            if (reset) begin
                chk($sformatf("rst_ready%0d", d), rdy[d], 1);
                chk($sformatf("rst_in_valid%0d", d), iv[d], 0);
                if (rst_prev) begin
                    chk($sformatf("rst_rsp_valid%0d", d), rv[d], 0);
                    chk($sformatf("rst_rsp_rdata%0d", d), rdat[d], 0);
                    chk($sformatf("rst_out_valid%0d", d), ov[d], 0);
                    chk($sformatf("rst_out_ch%0d", d), och[d], 0);
                end
                mhead[d] = 0;
                mtail[d] = 0;
                mslot[d] = 0;
                mrv[d] = 1'b0;
                mrd[d] = '0;
            end else begin
                size = mtail[d] - mhead[d];
                exp_rdy = !(req_wen && req_addr == 4'h0 && size == DEPTH);
                acc = v && exp_rdy;
                emit = (size > 0) && (mav[d][mhead[d] % 64] <= cyc) && (cyc >= mslot[d]);
                exp_iv = acc && !req_wen && req_addr == 4'h8 && RXEN;
                chk($sformatf("req_ready%0d", d), rdy[d], exp_rdy);
                chk($sformatf("rsp_valid%0d", d), rv[d], mrv[d]);
                if (mrv[d]) chk($sformatf("rsp_rdata%0d", d), rdat[d], mrd[d]);
                chk($sformatf("out_valid%0d", d), ov[d], emit);
                if (emit) chk($sformatf("out_ch%0d", d), och[d], mch[d][mhead[d] % 64]);
                chk($sformatf("in_valid%0d", d), iv[d], exp_iv);
                rd = '0;
                if (acc && !req_wen && req_addr == 4'h4) begin
                    rd[0] = (size == DEPTH);
                    rd[1] = (size == 0);
                    rd[2] = RXEN;
                    rd[15:8] = 8'(size);
                end
                if (acc && !req_wen && req_addr == 4'h8 && RXEN) rd[7:0] = uart_in_ch;
                mrv[d] = acc;
                mrd[d] = rd;
                if (emit) begin
                    mhead[d]++;
                    mslot[d] = cyc + 1 + gapof(d);
                end
                if (acc && req_wen && req_addr == 4'h0) begin
                    mch[d][mtail[d] % 64] = req_wdata;
                    mav[d][mtail[d] % 64] = cyc + 2;
                    mtail[d]++;
                end
            end
        end
        rst_prev = reset;
        cyc++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic access(input int d, input bit w, input logic [3:0] a, input logic [7:0] data);
        bit ok = 1'b0;
        req_wen = w;
        req_addr = a;
        req_wdata = data;
        if (d == 0) vld0 = 1'b1; else vld1 = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clock);
            ok = rdy[d];
            @(posedge clock);
            #1;
        end
        vld0 = 1'b0;
        vld1 = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic read(input int d, input logic [3:0] a, output logic [63:0] data);
        access(d, 1'b0, a, 8'h00);
        @(negedge clock);
        data = rdat[d];
        @(posedge clock);
        #1;
    endtask

    task automatic wait_emits(input int d, input int n, input int budget);
        for (int i = 0; i < budget && ecnt[d] < n; i++) idle(1);
        chk($sformatf("emit_count%0d", d), ecnt[d], n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        int t0, pre, n0;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);
        chk("post_reset_ready", rdy, 2'b11);
        chk("post_reset_out", ov, 2'b00);

        access(0, 1'b1, 4'h0, 8'h41);
        t0 = acc_cyc[0];
        idle(6);
        chk("single_count", ecnt[0], 1);
        chk("single_ch", ech[0][0], 8'h41);
        chk("single_latency", ecyc[0][0] - t0, 2);
        chk("single_rsp_latency", rsp_cyc[0] - t0, 1);

        read(0, 4'hC, d);
        chk("unmapped_read", d, 0);
        access(0, 1'b1, 4'hC, 8'h77);
        read(0, 4'h0, d);
        chk("txdata_read", d, 0);
        read(0, 4'h4, d);
        chk("status_empty", d, 64'h2 | RXBIT);

        for (int i = 0; i < 3; i++) access(0, 1'b1, 4'h0, 8'(8'h61 + i));
        wait_emits(0, 4, 50);
        chk("burst_ch_first", ech[0][1], 8'h61);
        chk("burst_ch_last", ech[0][3], 8'h63);
        chk("burst_span", ecyc[0][3] - ecyc[0][1], 2);

        uart_in_ch = 8'h5A;
        n0 = inv_cnt[0];
        read(0, 4'h8, d);
        chk("rxdata", d, RXEN ? 64'h5A : 64'h0);
        chk("rx_strobes", inv_cnt[0] - n0, RXEN ? 1 : 0);

        for (int i = 0; i < 12; i++) access(1, 1'b1, 4'h0, 8'(8'h30 + i));
        wait_emits(1, 12, 200);
        chk("full_stall_seen", stall_seen[1], 1);
        for (int k = 0; k < 12; k++) chk($sformatf("order_%0d", k), ech[1][k], 8'(8'h30 + k));
        for (int k = 1; k < 12; k++) chk($sformatf("spacing_%0d", k), ecyc[1][k] - ecyc[1][k-1], 5);

        idle(10);
        for (int i = 0; i < 3; i++) access(1, 1'b1, 4'h0, 8'(8'h71 + i));
        read(1, 4'h4, d);
        chk("status_busy", d, 64'h200 | RXBIT);
        wait_emits(1, 15, 100);
        idle(6);
        read(1, 4'h4, d);
        chk("status_drained", d, 64'h2 | RXBIT);

        for (int i = 0; i < 6; i++) access(1, 1'b1, 4'h0, 8'(8'h80 + i));
        reset = 1'b1;
        pre = ecnt[1];
        chk("pre_reset_emits", pre - 15, 1);
        idle(2);
        reset = 1'b0;
        idle(20);
        chk("no_emit_after_reset", ecnt[1], pre);
        read(1, 4'h4, d);
        chk("status_after_reset", d, 64'h2 | RXBIT);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
